lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Initiator side of the DPI memory port: accepts one load/store from the execute stage, drives the
//  valid/wen/raddr/waddr/wdata/wmask request into the memory controller, then samples rdata.
//  Load data is shifted, sign- or zero-extended and returned on a response handshake.
//  Sits between EXU and the memory controller; one outstanding access at a time.
// PARAMETERS
//  MEM_LAT   1   cycles mem_valid is held; rdata sampled on the last one (range 1..15)
//  XLEN      32  data/address width
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  req_valid    in   1     EXU request valid
//  req_ready    out  1     block can accept a request (state==IDLE)
//  req_wen      in   1     1=store, 0=load
//  req_size     in   2     00 byte, 01 half, 10 word; 11 is illegal
//  req_unsigned in   1     load zero-extends when 1
//  req_addr     in   XLEN  byte address
//  req_wdata    in   XLEN  store data, right-aligned
//  resp_valid   out  1     result available
//  resp_ready   in   1     EXU consumes result
//  resp_rdata   out  XLEN  extended load data (0 for stores/errors)
//  resp_err     out  1     misaligned or illegal size; no memory access made
//  mem_valid    out  1     to controller valid
//  mem_wen      out  1     to controller wen
//  mem_raddr    out  32    word-aligned address (addr & ~3)
//  mem_waddr    out  32    word-aligned address (addr & ~3)
//  mem_wdata    out  32    store data shifted left by 8*addr[1:0]
//  mem_wmask    out  8     byte mask; [7:4] always 0
//  mem_rdata    in   32    read data from controller
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; mem_valid/mem_wen 0; mem_* addr/data/mask 0; resp_valid 0,
//   resp_rdata 0, resp_err 0; LAT counter 0. req_ready goes 1 once state is IDLE.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. All mem_* and resp_* outputs are registers.
//  IDLE: on req_valid&&req_ready latch request. Misaligned (half with addr[0]=1, word with addr[1:0]!=0)
//   or size 11 -> go RESP directly, resp_err=1, resp_rdata=0, mem_valid stays 0.
//   Otherwise -> ACCESS, mem_valid=1, mem_wen=req_wen, counter=MEM_LAT-1.
//  wmask base: byte 0001, half 0011, word 1111, shifted left by addr[1:0]; 0 for loads.
//  ACCESS: mem_valid held; mem_wen is 1 only in the first ACCESS cycle (exactly one write per store).
//   Counter decrements each cycle; when counter==0 in this cycle: sample mem_rdata, deassert
//   mem_valid/mem_wen, go RESP. Total request-to-resp_valid latency = MEM_LAT+1 cycles.
//  Load extraction: d = mem_rdata >> 8*addr[1:0]; byte/half sign-extended from bit 7/15 unless
//   req_unsigned; word passes through. Stores return resp_rdata=0, resp_err=0.
//  RESP: resp_valid=1 held with stable data until resp_ready; on resp_valid&&resp_ready clear
//   resp_valid, -> IDLE. req_ready is 0 in RESP, so back-to-back requests need >=1 IDLE cycle.
//  resp_ready high before resp_valid has no effect. req_* ignored outside IDLE.
//  Reset mid-ACCESS: mem_valid drops immediately (async); a partially held store is not retried.
// STRUCTURE
//  lsu_pkg: size_e {SZ_B,SZ_H,SZ_W,SZ_BAD}, state_e {IDLE,ACCESS,RESP}, function size_mask(size).
//  Sub-module lsu_align (combinational): addr/size/wdata -> mem_wdata, mem_wmask, misalign flag;
//   mem_rdata/offset/size/unsigned -> extended load data. FSM, counter, registers live in top.
// TESTING
//  lw 0x8000_0004, mem_rdata=0xDEAD_BEEF, MEM_LAT=1 -> mem_raddr 0x8000_0004, resp_rdata 0xDEADBEEF @ cycle+2.
//  lb 0x8000_0003 signed, rdata=0x80FF_0000 -> resp 0xFFFF_FF80; lbu same -> 0x0000_0080.
//  sh 0x8000_0002 wdata 0x1234_ABCD -> mem_wdata 0xABCD_0000, mem_wmask 0x0C, mem_wen high 1 cycle only.
//  lw 0x8000_0001 -> resp_err=1, resp_rdata=0, mem_valid never asserted.
//  MEM_LAT=3, resp_ready low 5 cycles -> mem_valid high 3 cycles, resp_valid/data stable until ready.
//  rst_n low during ACCESS of sw -> mem_valid 0 same cycle, req_ready 1 after release, next lw works.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared types for the LSU memory master slice.
//   size_e    : access size encoding as carried on req_size
//   state_e   : master FSM states
//   CNT_W     : width of the access-latency counter (covers MEM_LAT up to 15)
//   size_mask : right-aligned byte-enable pattern for an access size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic [3:0] size_mask(input size_e s);
    logic [3:0] m;
    case (s)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Bus bundle for lsu_mem_master: the EXU request/response handshake plus
// the memory-controller request port.
// Handshake rule: a transfer happens on a rising edge where valid && ready
// are both 1; the initiator holds its payload stable while valid is high
// and ready is low. The memory side has no ready: mem_valid is held for
// MEM_LAT cycles and mem_rdata is sampled on the last one.
//   master modport : the LSU master (drives req_ready, resp_*, mem_*)
//   slave  modport : the environment (EXU + memory controller)
interface lsu_mem_master_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_valid;
  logic            mem_wen;
  logic [XLEN-1:0] mem_raddr;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_master_align.sv
// Combinational byte-lane alignment for the LSU.
// Store side (from the incoming request):
//   st_off/st_size/st_wdata -> st_wdata_sh (data moved to its byte lane),
//   st_wmask (byte enables, [7:4] always 0), st_err (misaligned or size 11)
// Load side (from the latched request and memory data):
//   ld_rdata/ld_off/ld_size/ld_uns -> ld_data (shifted down, sign/zero extended)
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_off,
  input  logic [1:0]      st_size,
  input  logic [XLEN-1:0] st_wdata,
  output logic [XLEN-1:0] st_wdata_sh,
  output logic [7:0]      st_wmask,
  output logic            st_err,
  input  logic [XLEN-1:0] ld_rdata,
  input  logic [1:0]      ld_off,
  input  logic [1:0]      ld_size,
  input  logic            ld_uns,
  output logic [XLEN-1:0] ld_data
);
  logic [3:0]      lane_mask;
  logic [XLEN-1:0] ld_shift;

  always_comb begin
    lane_mask   = size_mask(size_e'(st_size)) << st_off;
    st_wmask    = {4'b0000, lane_mask};
    st_wdata_sh = st_wdata << {st_off, 3'b000};
    case (size_e'(st_size))
      SZ_B:    st_err = 1'b0;
      SZ_H:    st_err = st_off[0];
      SZ_W:    st_err = (st_off != 2'b00);
      default: st_err = 1'b1;
    endcase
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    case (size_e'(ld_size))
      SZ_B:    ld_data = ld_uns ? {{(XLEN-8){1'b0}}, ld_shift[7:0]}
                                : {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = ld_uns ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                                : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end
endmodule

// File: rtl/lsu_mem_master.sv
// LSU memory master: takes one load/store from EXU, issues it to the memory
// controller for MEM_LAT cycles, and returns the (extended) load data on a
// response handshake. One access outstanding; FSM IDLE -> ACCESS -> RESP.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_mem_master_if.master (req_*, resp_*, mem_*)
//   dbg_state  : current FSM state
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_mem_master_if.master      bus,
  output state_e                dbg_state
);
  state_e          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Latched request attributes needed after IDLE.
  logic            lat_wen, lat_wen_n;
  logic [1:0]      lat_size, lat_size_n;
  logic            lat_uns, lat_uns_n;
  logic [1:0]      lat_off, lat_off_n;

  // Registered outputs.
  logic            mem_valid_q, mem_valid_n;
  logic            mem_wen_q, mem_wen_n;
  logic [XLEN-1:0] mem_addr_q, mem_addr_n;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_n;
  logic [7:0]      mem_wmask_q, mem_wmask_n;
  logic            resp_valid_q, resp_valid_n;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_n;
  logic            resp_err_q, resp_err_n;

  logic [XLEN-1:0] st_wdata_sh;
  logic [7:0]      st_wmask;
  logic            st_err;
  logic [XLEN-1:0] ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_off      (bus.req_addr[1:0]),
    .st_size     (bus.req_size),
    .st_wdata    (bus.req_wdata),
    .st_wdata_sh (st_wdata_sh),
    .st_wmask    (st_wmask),
    .st_err      (st_err),
    .ld_rdata    (bus.mem_rdata),
    .ld_off      (lat_off),
    .ld_size     (lat_size),
    .ld_uns      (lat_uns),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_wen      <= 1'b0;
      lat_size     <= 2'b00;
      lat_uns      <= 1'b0;
      lat_off      <= 2'b00;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lat_wen      <= lat_wen_n;
      lat_size     <= lat_size_n;
      lat_uns      <= lat_uns_n;
      lat_off      <= lat_off_n;
      mem_valid_q  <= mem_valid_n;
      mem_wen_q    <= mem_wen_n;
      mem_addr_q   <= mem_addr_n;
      mem_wdata_q  <= mem_wdata_n;
      mem_wmask_q  <= mem_wmask_n;
      resp_valid_q <= resp_valid_n;
      resp_rdata_q <= resp_rdata_n;
      resp_err_q   <= resp_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    lat_wen_n    = lat_wen;
    lat_size_n   = lat_size;
    lat_uns_n    = lat_uns;
    lat_off_n    = lat_off;
    mem_valid_n  = mem_valid_q;
    mem_wen_n    = mem_wen_q;
    mem_addr_n   = mem_addr_q;
    mem_wdata_n  = mem_wdata_q;
    mem_wmask_n  = mem_wmask_q;
    resp_valid_n = resp_valid_q;
    resp_rdata_n = resp_rdata_q;
    resp_err_n   = resp_err_q;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          lat_wen_n  = bus.req_wen;
          lat_size_n = bus.req_size;
          lat_uns_n  = bus.req_unsigned;
          lat_off_n  = bus.req_addr[1:0];
          if (st_err) begin
            // Bad requests never touch memory; answer straight away.
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = '0;
          end else begin
            state_n     = ACCESS;
            mem_valid_n = 1'b1;
            mem_wen_n   = bus.req_wen;
            mem_addr_n  = {bus.req_addr[XLEN-1:2], 2'b00};
            mem_wdata_n = bus.req_wen ? st_wdata_sh : '0;
            mem_wmask_n = bus.req_wen ? st_wmask : 8'h00;
            cnt_n       = CNT_W'(MEM_LAT - 1);
            resp_err_n  = 1'b0;
          end
        end
      end
      ACCESS: begin
        // wen only in the first ACCESS cycle so a store writes exactly once.
        mem_wen_n = 1'b0;
        if (cnt == '0) begin
          mem_valid_n  = 1'b0;
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = lat_wen ? '0 : ld_data;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_raddr  = mem_addr_q;
  assign bus.mem_waddr  = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- two DUTs: MEM_LAT=1 and MEM_LAT=3 ----------------
  lsu_mem_master_if #(.XLEN(32)) b1 ();
  lsu_mem_master_if #(.XLEN(32)) b3 ();
  state_e st1, st3;

  lsu_mem_master #(.MEM_LAT(1), .XLEN(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(st1));
  lsu_mem_master #(.MEM_LAT(3), .XLEN(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .dbg_state(st3));

  // Shared stimulus; sel picks which DUT sees req_valid/resp_ready.
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;

  assign b1.req_valid = req_valid & ~sel;
  assign b3.req_valid = req_valid & sel;
  assign b1.resp_ready = resp_ready & ~sel;
  assign b3.resp_ready = resp_ready & sel;
  assign b1.req_wen = req_wen;           assign b3.req_wen = req_wen;
  assign b1.req_size = req_size;         assign b3.req_size = req_size;
  assign b1.req_unsigned = req_unsigned; assign b3.req_unsigned = req_unsigned;
  assign b1.req_addr = req_addr;         assign b3.req_addr = req_addr;
  assign b1.req_wdata = req_wdata;       assign b3.req_wdata = req_wdata;
  assign b1.mem_rdata = mem_rdata;       assign b3.mem_rdata = mem_rdata;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_wen;
  logic [31:0] o_resp_rdata, o_mem_raddr, o_mem_waddr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  state_e      o_state;
  assign o_req_ready  = sel ? b3.req_ready  : b1.req_ready;
  assign o_resp_valid = sel ? b3.resp_valid : b1.resp_valid;
  assign o_resp_err   = sel ? b3.resp_err   : b1.resp_err;
  assign o_resp_rdata = sel ? b3.resp_rdata : b1.resp_rdata;
  assign o_mem_valid  = sel ? b3.mem_valid  : b1.mem_valid;
  assign o_mem_wen    = sel ? b3.mem_wen    : b1.mem_wen;
  assign o_mem_raddr  = sel ? b3.mem_raddr  : b1.mem_raddr;
  assign o_mem_waddr  = sel ? b3.mem_waddr  : b1.mem_waddr;
  assign o_mem_wdata  = sel ? b3.mem_wdata  : b1.mem_wdata;
  assign o_mem_wmask  = sel ? b3.mem_wmask  : b1.mem_wmask;
  assign o_state      = sel ? st3 : st1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One full transaction on the selected DUT. lat is that DUT's MEM_LAT,
  // hold is how many cycles resp_ready stays low once resp_valid is seen,
  // early drives resp_ready high before the request is even issued.
  task automatic run_txn(input string tag, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic [31:0] exp_wdata,
                         input logic [7:0] exp_wmask, input int lat, input int hold,
                         input logic early);
    int n, mv, wc;
    logic [31:0] cap_raddr, cap_waddr, cap_wdata, rd0;
    logic [7:0]  cap_wmask;
    logic stable;
    logic [31:0] exp_v;
    @(negedge clk);
    check({tag, ".req_ready"}, {31'b0, o_req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; mem_rdata = rdata; resp_ready = early;
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; mv = 0; wc = 0;
    cap_raddr = '0; cap_waddr = '0; cap_wdata = '0; cap_wmask = '0;
    while (!o_resp_valid && n < 40) begin
      if (o_mem_valid) begin
        if (mv == 0) begin
          cap_raddr = o_mem_raddr; cap_waddr = o_mem_waddr;
          cap_wdata = o_mem_wdata; cap_wmask = o_mem_wmask;
        end
        mv++;
      end
      if (o_mem_wen) wc++;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n + 1, exp_err ? 32'd1 : lat + 1);
    check({tag, ".resp_valid"}, {31'b0, o_resp_valid}, 32'd1);
    exp_v = exp_q.pop_front();
    check({tag, ".resp_rdata"}, o_resp_rdata, exp_v);
    check({tag, ".resp_err"}, {31'b0, o_resp_err}, {31'b0, exp_err});
    check({tag, ".mem_valid_cycles"}, mv, exp_err ? 32'd0 : lat);
    check({tag, ".mem_wen_cycles"}, wc, (wen && !exp_err) ? 32'd1 : 32'd0);
    if (!exp_err) begin
      check({tag, ".mem_raddr"}, cap_raddr, addr & 32'hFFFF_FFFC);
      check({tag, ".mem_waddr"}, cap_waddr, addr & 32'hFFFF_FFFC);
      check({tag, ".mem_wmask"}, {24'b0, cap_wmask}, {24'b0, exp_wmask});
      if (wen) check({tag, ".mem_wdata"}, cap_wdata, exp_wdata);
    end
    if (!early) begin
      rd0 = o_resp_rdata;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!o_resp_valid || o_resp_rdata !== rd0 || o_mem_valid) stable = 1'b0;
      end
      check({tag, ".resp_stable"}, {31'b0, stable}, 32'd1);
      resp_ready = 1'b1;
    end
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ".resp_cleared"}, {31'b0, o_resp_valid}, 32'd0);
    check({tag, ".back_idle"}, {31'b0, o_req_ready}, 32'd1);
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    // Reset values while rst_n is low.
    check("rst.req_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst.state", {30'b0, o_state}, {30'b0, IDLE});
    check("rst.mem_valid", {31'b0, o_mem_valid}, 32'd0);
    check("rst.mem_wen", {31'b0, o_mem_wen}, 32'd0);
    check("rst.mem_raddr", o_mem_raddr, 32'd0);
    check("rst.mem_wdata", o_mem_wdata, 32'd0);
    check("rst.mem_wmask", {24'b0, o_mem_wmask}, 32'd0);
    check("rst.resp_valid", {31'b0, o_resp_valid}, 32'd0);
    check("rst.resp_rdata", o_resp_rdata, 32'd0);
    check("rst.resp_err", {31'b0, o_resp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MEM_LAT = 1
    sel = 1'b0;
    run_txn("lw",      1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0, 8'h00, 1, 0, 1'b0);
    run_txn("lb",      1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 32'h0, 8'h00, 1, 1, 1'b0);
    run_txn("lbu",     1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 32'h0000_0080, 1'b0, 32'h0, 8'h00, 1, 0, 1'b0);
    run_txn("sh",      1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'hABCD_0000, 8'h0C, 1, 0, 1'b0);
    run_txn("lw_mis",  1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 32'h0, 8'h00, 1, 2, 1'b0);
    run_txn("lh_early",1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 32'h0, 8'h00, 1, 0, 1'b1);
    run_txn("size11",  1'b0, 2'b11, 1'b0, 32'h8000_0000, 32'h0, 32'h2222_2222, 32'h0, 1'b1, 32'h0, 8'h00, 1, 0, 1'b0);
    run_txn("sb",      1'b1, 2'b00, 1'b0, 32'h8000_0001, 32'h0000_00A5, 32'h0, 32'h0, 1'b0, 32'h0000_A500, 8'h02, 1, 0, 1'b0);
    run_txn("lhu_mis", 1'b0, 2'b01, 1'b1, 32'h8000_0001, 32'h0, 32'h3333_3333, 32'h0, 1'b1, 32'h0, 8'h00, 1, 0, 1'b0);
    run_txn("lhu",     1'b0, 2'b01, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_F00D, 32'h0000_F00D, 1'b0, 32'h0, 8'h00, 1, 0, 1'b0);

    // MEM_LAT = 3
    @(negedge clk);
    sel = 1'b1;
    run_txn("lw3",     1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'h0, 8'h00, 3, 5, 1'b0);
    run_txn("sw3",     1'b1, 2'b10, 1'b0, 32'h1000_000C, 32'h1122_3344, 32'h0, 32'h0, 1'b0, 32'h1122_3344, 8'h0F, 3, 0, 1'b0);

    // Reset in the middle of a store access.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h1000_0010; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid.mem_valid_before", {31'b0, o_mem_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid.mem_valid_async", {31'b0, o_mem_valid}, 32'd0);
    check("mid.mem_wen_async", {31'b0, o_mem_wen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.req_ready_after", {31'b0, o_req_ready}, 32'd1);
    check("mid.no_retry", {31'b0, o_mem_valid}, 32'd0);
    run_txn("lw_after", 1'b0, 2'b10, 1'b0, 32'h1000_0014, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 32'h0, 8'h00, 3, 1, 1'b0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=0x%08h exp=0x%08h", checks, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
